// File: rtl/edabk_uart_pkg.sv
// Shared types and frame constants for the EDABK UART transmitter.
// Supplies default CFG_CLK_DIV / CFG_DATA_WIDTH when the build does not define them.
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

package edabk_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;

  localparam int unsigned START_BITS    = 1;
  localparam int unsigned PARITY_BITS   = 1;
  localparam int unsigned MAX_STOP_BITS = 2;

  // The reserved code 2'b11 behaves as "no parity".
  function automatic par_mode_e decode_parity(input logic [1:0] cfg);
    case (cfg)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

  function automatic int unsigned frame_bits(input int unsigned nbits, input logic par_en,
                                             input logic stop2);
    return START_BITS + nbits + (par_en ? PARITY_BITS : 0) + (stop2 ? MAX_STOP_BITS : 1);
  endfunction

endpackage

// File: rtl/edabk_uart_bit_timer.sv
// Bit-period timer: counts 0..CLK_DIV-1 and flags the last cycle of each serial bit.
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif

module edabk_uart_bit_timer
  import edabk_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = `CFG_CLK_DIV
) (
  input  logic bclk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (restart || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);

endmodule

// File: rtl/edabk_uart_tx_engine.sv
// UART frame transmitter: start, 5..DATA_WIDTH data bits LSB first, optional parity, 1/2 stop.
// Optional line-break input is built when EDABK_UART_TX_BREAK_EN is defined.
`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_uart_tx_engine
  import edabk_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = `CFG_CLK_DIV,
  parameter int unsigned DATA_WIDTH = `CFG_DATA_WIDTH,
  parameter int unsigned NB_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  bclk,
  input  logic                  reset_n,
`ifdef EDABK_UART_TX_BREAK_EN
  input  logic                  tx_break,
`endif
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [NB_WIDTH-1:0]   cfg_nbits,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  finish
);

  localparam logic [NB_WIDTH-1:0] NB_MAX = NB_WIDTH'(DATA_WIDTH);

  tx_state_e             r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [NB_WIDTH-1:0]   r_nbits;
  logic [NB_WIDTH-1:0]   r_bit_cnt;
  par_mode_e             r_par_mode;
  logic                  r_stop2;
  logic                  r_stop_cnt;
  logic                  r_parity;
  logic                  r_tx_out;

  logic                  w_tick;
  logic                  w_accept;
  logic                  w_idle_line;
  logic                  w_last_data;
  logic [NB_WIDTH-1:0]   w_nbits_clamped;

  // Timer is held at zero while idle so the start bit gets a full period.
  edabk_uart_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .bclk    (bclk),
    .reset_n (reset_n),
    .restart (r_state == StIdle),
    .tick    (w_tick)
  );

`ifdef EDABK_UART_TX_BREAK_EN
  logic r_break;

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_break <= 1'b0;
    end else if ((r_state == StIdle) && !w_accept) begin
      r_break <= tx_break;
    end
  end

  assign tx_ready    = (r_state == StIdle) && !r_break;
  assign w_idle_line = ~tx_break;
`else
  assign tx_ready    = (r_state == StIdle);
  assign w_idle_line = 1'b1;
`endif

  assign w_accept        = tx_valid && tx_ready;
  assign w_nbits_clamped = ((cfg_nbits == '0) || (cfg_nbits > NB_MAX)) ? NB_MAX : cfg_nbits;
  assign w_last_data     = (r_bit_cnt == (r_nbits - NB_WIDTH'(1)));

  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_shift    <= '0;
      r_nbits    <= '0;
      r_bit_cnt  <= '0;
      r_par_mode <= PAR_NONE;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx_out   <= 1'b1;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_tx_out <= w_idle_line;
          if (w_accept) begin
            r_shift    <= tx_data;
            r_nbits    <= w_nbits_clamped;
            r_par_mode <= decode_parity(cfg_parity);
            r_stop2    <= cfg_stop2;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_tx_out   <= 1'b0;
            r_state    <= StStart;
          end
        end
        StStart: begin
          if (w_tick) begin
            r_tx_out  <= r_shift[0];
            r_parity  <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= '0;
            r_state   <= StData;
          end
        end
        StData: begin
          if (w_tick) begin
            if (w_last_data) begin
              if (r_par_mode != PAR_NONE) begin
                r_tx_out <= (r_par_mode == PAR_ODD) ? ~r_parity : r_parity;
                r_state  <= StParity;
              end else begin
                r_tx_out   <= 1'b1;
                r_stop_cnt <= 1'b0;
                r_state    <= StStop;
              end
            end else begin
              r_tx_out  <= r_shift[0];
              r_parity  <= r_parity ^ r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_cnt <= r_bit_cnt + NB_WIDTH'(1);
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            r_tx_out   <= 1'b1;
            r_stop_cnt <= 1'b0;
            r_state    <= StStop;
          end
        end
        StStop: begin
          if (w_tick) begin
            r_tx_out <= 1'b1;
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: begin
          r_tx_out <= 1'b1;
          r_state  <= StIdle;
        end
      endcase
    end
  end

  assign tx_out = r_tx_out;
  assign busy   = (r_state != StIdle);
  assign finish = (r_state == StStop) && w_tick && (!r_stop2 || r_stop_cnt);

endmodule

// File: tb/tb_edabk_uart_tx_engine.sv
// Bench for edabk_uart_tx_engine: table-driven frames checked against a scoreboard queue.
// Break scenarios are compiled only when EDABK_UART_TX_BREAK_EN is defined.
`timescale 1ns/1ps

module tb_edabk_uart_tx_engine;

  localparam int unsigned CLK_DIV    = 16;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned NB_WIDTH   = 4;

  logic                  bclk       = 1'b0;
  logic                  reset_n    = 1'b1;
  logic                  tx_valid   = 1'b0;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data    = '0;
  logic [NB_WIDTH-1:0]   cfg_nbits  = '0;
  logic [1:0]            cfg_parity = '0;
  logic                  cfg_stop2  = 1'b0;
  logic                  tx_out;
  logic                  busy;
  logic                  finish;
`ifdef EDABK_UART_TX_BREAK_EN
  logic                  tx_break   = 1'b0;
`endif

  always #5 bclk = ~bclk;

  edabk_uart_tx_engine #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .bclk       (bclk),
    .reset_n    (reset_n),
`ifdef EDABK_UART_TX_BREAK_EN
    .tx_break   (tx_break),
`endif
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .cfg_nbits  (cfg_nbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .tx_out     (tx_out),
    .busy       (busy),
    .finish     (finish)
  );

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] nbits;
    logic [1:0] par;
    logic       stop2;
    int         exp_len;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  frame_t sb_q[$];
  vec_t   vecs[6];

  logic       hold_valid = 1'b0;
  logic [7:0] nxt_data;
  logic [3:0] nxt_nbits;
  logic [1:0] nxt_par;
  logic       nxt_stop2;
  int         brk_cycle  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start, clamped data LSB first, optional parity, stop bit(s).
  function automatic frame_t model(input logic [7:0] d, input logic [3:0] nb,
                                   input logic [1:0] par, input logic stop2);
    frame_t f;
    int     n;
    logic   p;
    n      = (nb == 4'd0 || nb > 4'd8) ? 8 : int'(nb);
    f.bits = '1;
    f.n    = 0;
    p      = 1'b0;
    f.bits[f.n] = 1'b0;
    f.n++;
    for (int i = 0; i < n; i++) begin
      f.bits[f.n] = d[i];
      p = p ^ d[i];
      f.n++;
    end
    if (par == 2'b01) begin
      f.bits[f.n] = p;
      f.n++;
    end else if (par == 2'b10) begin
      f.bits[f.n] = ~p;
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (stop2) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                      input logic stop2);
    int w = 0;
    @(negedge bclk);
    while (!tx_ready && w < 400) begin
      @(negedge bclk);
      w++;
    end
    check("ready_before_send", {31'b0, tx_ready}, 32'd1);
    tx_data    = d;
    cfg_nbits  = nb;
    cfg_parity = par;
    cfg_stop2  = stop2;
    tx_valid   = 1'b1;
    sb_q.push_back(model(d, nb, par, stop2));
  endtask

  // Called from a negedge with tx_valid high; the next posedge is the handshake.
  task automatic check_frame(input string tag, input int exp_len);
    frame_t     f;
    int         fin_cycle = 0;
    int         fin_cnt   = 0;
    int         cyc;
    logic [2:0] act_s;
    logic [2:0] exp_s;
    logic       bad;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got 0 entries expected 1", tag);
      return;
    end
    f = sb_q.pop_front();
    @(posedge bclk);
    #1;
    if (hold_valid) begin
      tx_data    = nxt_data;
      cfg_nbits  = nxt_nbits;
      cfg_parity = nxt_par;
      cfg_stop2  = nxt_stop2;
      sb_q.push_back(model(nxt_data, nxt_nbits, nxt_par, nxt_stop2));
      hold_valid = 1'b0;
    end else begin
      // Scramble inputs to show the latched frame ignores them.
      tx_valid   = 1'b0;
      tx_data    = 8'($urandom);
      cfg_nbits  = 4'($urandom);
      cfg_parity = 2'($urandom);
      cfg_stop2  = 1'($urandom);
    end
    for (int b = 0; b < f.n; b++) begin
      exp_s = {f.bits[b], 2'b10};
      act_s = exp_s;
      bad   = 1'b0;
      for (int c = 0; c < int'(CLK_DIV); c++) begin
        @(negedge bclk);
        cyc = b * int'(CLK_DIV) + c + 1;
`ifdef EDABK_UART_TX_BREAK_EN
        if (cyc == brk_cycle) tx_break = 1'b1;
`endif
        if (!bad && ({tx_out, busy, tx_ready} !== exp_s)) begin
          bad   = 1'b1;
          act_s = {tx_out, busy, tx_ready};
        end
        if (finish === 1'b1) begin
          fin_cnt++;
          fin_cycle = cyc;
        end
      end
      check($sformatf("%s bit%0d {line,busy,ready}", tag, b), {29'b0, act_s}, {29'b0, exp_s});
    end
    check($sformatf("%s finish_cycle", tag), fin_cycle, exp_len);
    check($sformatf("%s finish_pulses", tag), fin_cnt, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 4'd8,  2'b01, 1'b0, 176};
    vecs[1] = '{8'h13, 4'd5,  2'b10, 1'b1, 144};
    vecs[2] = '{8'h3C, 4'd0,  2'b00, 1'b0, 160};
    vecs[3] = '{8'h5A, 4'd12, 2'b01, 1'b1, 192};
    vecs[4] = '{8'hFF, 4'd7,  2'b11, 1'b0, 144};
    vecs[5] = '{8'h81, 4'd6,  2'b10, 1'b0, 144};

    #1 reset_n = 1'b0;
    #1;
    check("reset tx_out", {31'b0, tx_out}, 32'd1);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset tx_ready", {31'b0, tx_ready}, 32'd1);
    check("reset finish", {31'b0, finish}, 32'd0);
    repeat (3) @(negedge bclk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].nbits, vecs[i].par, vecs[i].stop2);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_len);
    end

    // Back-to-back: valid stays high, second frame must start after one idle cycle.
    send(8'h3C, 4'd8, 2'b01, 1'b1);
    hold_valid = 1'b1;
    nxt_data   = 8'hC3;
    nxt_nbits  = 4'd6;
    nxt_par    = 2'b10;
    nxt_stop2  = 1'b0;
    check_frame("b2b_a", 192);
    @(negedge bclk);
    check("b2b gap {line,busy,ready}", {29'b0, tx_out, busy, tx_ready}, 32'b101);
    check_frame("b2b_b", 144);

    // Reset in the middle of data bit 3 (cycles 65..80 of the frame).
    send(8'hA5, 4'd8, 2'b00, 1'b0);
    void'(sb_q.pop_back());
    @(posedge bclk);
    #1 tx_valid = 1'b0;
    repeat (70) @(negedge bclk);
    check("pre_reset {line,busy}", {30'b0, tx_out, busy}, 32'b01);
    reset_n = 1'b0;
    #1;
    check("mid_reset {line,busy,ready,finish}", {28'b0, tx_out, busy, tx_ready, finish},
          32'b1010);
    @(negedge bclk);
    reset_n = 1'b1;
    send(8'h96, 4'd8, 2'b10, 1'b0);
    check_frame("after_reset", 176);

`ifdef EDABK_UART_TX_BREAK_EN
    begin
      logic brk_bad;
      brk_bad = 1'b0;
      @(negedge bclk);
      tx_break = 1'b1;
      repeat (200) begin
        @(negedge bclk);
        if (tx_out !== 1'b0 || tx_ready !== 1'b0) brk_bad = 1'b1;
      end
      check("break held {line/ready bad}", {31'b0, brk_bad}, 32'd0);
      tx_break = 1'b0;
      @(negedge bclk);
      check("break release {line,ready}", {30'b0, tx_out, tx_ready}, 32'b11);
      brk_cycle = 40;
      send(8'h55, 4'd8, 2'b00, 1'b0);
      check_frame("break_mid_frame", 160);
      tx_break  = 1'b0;
      brk_cycle = -1;
      repeat (3) @(negedge bclk);
      check("break cleared ready", {31'b0, tx_ready}, 32'd1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
